// File: rtl/escape_rate_estimator.sv
// Escape-bit estimator for coeff_abs_level_remaining (HM Golomb-Rice / Exp-Golomb).
// Tracks the adaptive Rice parameter and a saturating escape-bit total per CG.
module escape_rate_estimator #(
  parameter int ABS_W    = 16,
  parameter int MAX_RICE = 4,
  parameter int BIN_RED  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ABS_W-1:0] abs_level,
  input  logic [7:0]       base_level,
  input  logic             first_in_cg,
  input  logic             last_in_cg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       esc_bits,
  output logic [2:0]       rice_used,
  output logic [15:0]      cg_bits,
  output logic             cg_last
);

  localparam int LW = ABS_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_EVAL, S_ESC, S_FIN, S_OUT
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [ABS_W-1:0] r_abs;
  logic [7:0]       r_base;
  logic             r_first;
  logic             r_last;
  logic [2:0]       r_r;
  logic [2:0]       r_rice;
  logic [4:0]       r_len;
  logic [LW-1:0]    r_rem;
  logic [7:0]       r_bits;
  logic [15:0]      r_cg_bits;

  logic [ABS_W-1:0] w_base_ext;
  logic [ABS_W-1:0] w_sym;
  logic [ABS_W-1:0] w_sym_sh;
  logic [LW-1:0]    w_sym_ext;
  logic [LW-1:0]    w_thr;
  logic [LW-1:0]    w_pow;
  logic [LW-1:0]    w_rice_thr;
  logic             w_lt;
  logic             w_short;
  logic             w_step;
  logic             w_rice_up;
  logic [2:0]       w_rice_inc;
  logic [7:0]       w_short_bits;
  logic [7:0]       w_esc_bits;
  logic [16:0]      w_sum;
  logic [15:0]      w_cg_next;

  assign w_base_ext = {{(ABS_W-8){1'b0}}, r_base};
  assign w_lt       = r_abs < w_base_ext;
  assign w_sym      = r_abs - w_base_ext;
  assign w_sym_ext  = {1'b0, w_sym};
  assign w_sym_sh   = w_sym >> r_r;
  assign w_thr      = LW'(BIN_RED) << r_r;
  assign w_short    = w_sym_ext < w_thr;
  assign w_pow      = LW'(1) << r_len;
  assign w_step     = (r_rem >= w_pow) && (r_len < 5'(ABS_W));
  assign w_rice_thr = LW'(3) << r_r;
  assign w_rice_up  = {1'b0, r_abs} > w_rice_thr;
  assign w_rice_inc = (r_r < 3'(MAX_RICE)) ? r_r + 3'd1 : 3'(MAX_RICE);

  assign w_short_bits = w_sym_sh[7:0] + {5'd0, r_r} + 8'd1;
  // Prefix of BIN_RED+len+1-r ones/terminator followed by a len-bit suffix.
  assign w_esc_bits = 8'(BIN_RED) + {2'b0, r_len, 1'b0}
                    + 8'd1 - {5'd0, r_r};

  assign w_sum     = {1'b0, (r_first ? 16'd0 : r_cg_bits)}
                   + {9'd0, r_bits};
  assign w_cg_next = w_sum[16] ? 16'hFFFF : w_sum[15:0];

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_OUT);
  assign esc_bits  = r_bits;
  assign rice_used = r_r;
  assign cg_bits   = r_cg_bits;
  assign cg_last   = r_last;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (in_valid) w_next = S_EVAL;
      S_EVAL: w_next = (w_lt || w_short) ? S_FIN : S_ESC;
      S_ESC:  if (!w_step) w_next = S_FIN;
      S_FIN:  w_next = S_OUT;
      S_OUT:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_abs     <= '0;
      r_base    <= '0;
      r_first   <= 1'b0;
      r_last    <= 1'b0;
      r_r       <= '0;
      r_rice    <= '0;
      r_len     <= '0;
      r_rem     <= '0;
      r_bits    <= '0;
      r_cg_bits <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: if (in_valid) begin
          r_abs   <= abs_level;
          r_base  <= base_level;
          r_first <= first_in_cg;
          r_last  <= last_in_cg;
          r_r     <= first_in_cg ? 3'd0 : r_rice;
        end
        S_EVAL: begin
          if (w_lt) begin
            r_bits <= 8'd0;
          end else if (w_short) begin
            r_bits <= w_short_bits;
          end else begin
            r_len <= {2'b0, r_r};
            r_rem <= w_sym_ext - w_thr;
          end
        end
        S_ESC: begin
          if (w_step) begin
            r_rem <= r_rem - w_pow;
            r_len <= r_len + 5'd1;
          end else begin
            r_bits <= w_esc_bits;
          end
        end
        S_FIN: r_cg_bits <= w_cg_next;
        S_OUT: if (out_ready && !w_lt) begin
          r_rice <= w_rice_up ? w_rice_inc : r_r;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_escape_rate_estimator.sv
// Directed bench for escape_rate_estimator.
// Expected values below are hand-derived from the binarization rules.
module tb_escape_rate_estimator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] abs_level = '0;
  logic [7:0]  base_level = '0;
  logic        first_in_cg = 1'b0;
  logic        last_in_cg = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  esc_bits;
  logic [2:0]  rice_used;
  logic [15:0] cg_bits;
  logic        cg_last;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  escape_rate_estimator dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .abs_level(abs_level), .base_level(base_level),
    .first_in_cg(first_in_cg), .last_in_cg(last_in_cg),
    .out_valid(out_valid), .out_ready(out_ready),
    .esc_bits(esc_bits), .rice_used(rice_used),
    .cg_bits(cg_bits), .cg_last(cg_last)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic start(input logic [15:0] a, input logic [7:0] b,
                       input logic f, input logic l);
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    abs_level   = a;
    base_level  = b;
    first_in_cg = f;
    last_in_cg  = l;
    in_valid    = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic coef(input string tag, input logic [15:0] a,
                      input logic [7:0] b, input logic f,
                      input logic l, input int e_bits,
                      input int e_rice, input int e_cg,
                      input int e_lat, input int stall);
    int lat;
    logic [7:0]  h_bits;
    logic [15:0] h_cg;
    logic [2:0]  h_rice;
    out_ready = (stall == 0);
    start(a, b, f, l);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    chk({tag, "_lat"}, lat, e_lat);
    chk({tag, "_bits"}, esc_bits, e_bits);
    chk({tag, "_rice"}, rice_used, e_rice);
    chk({tag, "_cg"}, cg_bits, e_cg);
    chk({tag, "_last"}, cg_last, l);
    h_bits = esc_bits;
    h_cg   = cg_bits;
    h_rice = rice_used;
    for (int i = 0; i < stall; i++) begin
      abs_level  = 16'd999;
      base_level = 8'd1;
      in_valid   = i[0];
      @(posedge clk);
      #1;
      chk({tag, "_hold_v"}, out_valid, 1);
      chk({tag, "_hold_rdy"}, in_ready, 0);
      chk({tag, "_hold_bits"}, esc_bits, h_bits);
      chk({tag, "_hold_cg"}, cg_bits, h_cg);
      chk({tag, "_hold_rice"}, rice_used, h_rice);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 chk({tag, "_done"}, out_valid, 0);
    chk({tag, "_idle"}, in_ready, 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_bits", esc_bits, 0);
    chk("rst_rice", rice_used, 0);
    chk("rst_cg", cg_bits, 0);
    chk("rst_last", cg_last, 0);
    @(negedge clk) rst = 1'b0;

    coef("c1",  16'd5,   8'd3, 1, 0, 3,  0, 3,  2, 0);
    coef("c2",  16'd10,  8'd1, 0, 0, 7,  1, 10, 4, 0);
    coef("c3",  16'd1,   8'd2, 0, 0, 0,  2, 10, 2, 0);
    coef("c4",  16'd3,   8'd3, 1, 0, 1,  0, 1,  2, 0);
    coef("c5",  16'd3,   8'd3, 0, 0, 1,  0, 2,  2, 0);
    coef("c6",  16'd200, 8'd1, 0, 0, 18, 0, 20, 10, 0);
    coef("c7",  16'd200, 8'd1, 0, 0, 17, 1, 37, 9, 0);
    coef("c8",  16'd200, 8'd1, 0, 0, 16, 2, 53, 8, 0);
    coef("c9",  16'd200, 8'd1, 0, 0, 15, 3, 68, 7, 0);
    coef("c10", 16'd200, 8'd1, 0, 1, 14, 4, 82, 6, 0);
    coef("c11", 16'd5,   8'd1, 0, 0, 5,  4, 87, 2, 0);
    coef("c12", 16'd5,   8'd3, 1, 0, 3,  0, 3,  2, 5);

    start(16'd200, 8'd1, 0, 1);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_bits", esc_bits, 0);
    chk("abort_rice", rice_used, 0);
    chk("abort_cg", cg_bits, 0);
    chk("abort_last", cg_last, 0);
    @(negedge clk) rst = 1'b0;

    coef("c13", 16'd5, 8'd3, 0, 0, 3, 0, 3, 2, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
